rr_mux_reg: RTL and testbench
=============================

# rr_mux_reg

Registered N-way multiplexer with valid/ready handshakes and round-robin channel selection. Generalises the processor's combinational 2:1 and 3:1 selectors to a parametrised N-input, WIDTH-bit datapath. Holds one word in an output register so multiple producers share one consumer without combinational paths from consumer to data. Sits between request sources (fetch, load/store ports, debug) and a shared memory or bus port in the pipelined core.

## Interface
- WIDTH, 32, data width in bits (≥1)
- N, 4, number of input channels (≥2, need not be a power of two)
- SELW, $clog2(N), width of the channel index (derived, not overridden)

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk
- in_valid  input  N  per-channel request; bit i belongs to channel i
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  N  one-hot or zero; bit i high = channel i's word is taken this edge
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  held word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts the held word this edge

## Operation
- Register states: EMPTY (out_valid=0) and FULL (out_valid=1).
- load = !out_valid || out_ready. A channel can be taken only when load=1.
- Arbitration: the candidate order is last+1, last+2, …, last+N (mod N), where last is the index of the most recently granted channel. The first candidate with in_valid high wins. grant is one-hot or zero.
- in_ready = grant when load=1, otherwise zero. in_ready depends combinationally on in_valid and out_ready. It never depends on in_data.
- On an edge with any grant:
  - out_data and out_sel take the winner's data and index.
  - out_valid goes to 1.
  - last takes the winner's index.
- On an edge with load=1 and no in_valid: out_valid goes to 0. out_data and out_sel hold their values (don't-care).
- On an edge with out_valid=1 and out_ready=0: all registers hold and in_ready=0.
- Modulo wrap: the pointer wraps from N-1 to 0, including when N is not a power of two. Indices ≥ N are never produced.
- Reset values:
  - out_valid=0, out_data=0, out_sel=0.
  - last=N-1, so channel 0 has top priority after reset.
  - in_ready=0 during the reset cycle, regardless of inputs.
- Reset mid-operation: a word held in the output register is discarded. It is not presented after reset.
- Producers must hold in_valid and in_data stable until in_ready. The consumer sees out_data stable while out_valid=1 and out_ready=0.

## Timing
- Latency: 1 cycle. A word granted at edge k is visible on out_data/out_valid after edge k.
- Throughput: 1 word per cycle with out_ready held high. Simultaneous drain and load in the same edge costs no bubble.
- Fairness: with all N channels continuously valid and out_ready=1, each channel is granted exactly once in every N consecutive grants.
- A single active channel is granted every cycle. It is not starved by the pointer.
- Backpressure: out_ready=0 while FULL stalls every producer on the same cycle (in_ready=0 combinationally).
- No combinational path from in_data to out_data.

## Test plan
- Reset, then hold all in_valid=0 for 3 cycles. Expect out_valid=0, out_data=0, out_sel=0 and in_ready=0 throughout.
- N=4, WIDTH=32, all channels valid with data 0xA0+i, out_ready=1. Expect out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with out_data matching 0xA0+out_sel. Expect one in_ready bit per cycle.
- Only channel 2 valid (0xDEADBEEF), out_ready=1. Expect in_ready=0b0100 every cycle and out_valid continuously high.
- Grant channel 1 (0x11), then drive out_ready=0 for 4 cycles with channels 0 and 3 valid. Expect:
  - out_data to stay 0x11 and in_ready=0 during the stall.
  - on release, channel 3 granted before channel 0.
- N=3: all valid for 7 grants. Expect out_sel sequence 0,1,2,0,1,2,0 and no value 3 ever.
- Load channel 0 (0x55) with out_ready=0, then assert reset for one cycle. Expect:
  - out_valid=0 and out_data=0 after reset; 0x55 never appears.
  - channel 0 wins first when channels 0 and 1 are both valid.

Source files
------------

// File: rtl/rr_mux_reg.sv
// Registered N-way round-robin multiplexer with valid/ready handshakes on every
// input channel and a single-word output register toward one shared consumer.
//
// state | meaning
// EMPTY | output register holds no word (out_valid=0)
// FULL  | output register holds a word from channel out_sel (out_valid=1)
module rr_mux_reg #(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SELW-1:0]  last_q;
    logic [SELW-1:0]  sel_q;
    logic [WIDTH-1:0] data_q;

    logic [SELW-1:0]  win_idx;
    logic [SELW:0]    cand;
    logic [N-1:0]     grant;
    logic             found;
    logic             load;
    logic             take;
    logic [WIDTH-1:0] win_data;

    assign out_valid = (state == FULL);
    assign out_data  = data_q;
    assign out_sel   = sel_q;

    assign load = !out_valid || out_ready;

    // Search last+1 .. last+N; the extra bit in cand lets the sum exceed N-1
    // before folding back, so non-power-of-two N never yields an index >= N.
    always_comb begin
        grant   = '0;
        win_idx = last_q;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = {1'b0, last_q} + (SELW+1)'(k);
            if (cand >= (SELW+1)'(N)) begin
                cand = cand - (SELW+1)'(N);
            end
            if (!found && in_valid[cand[SELW-1:0]]) begin
                found                   = 1'b1;
                grant[cand[SELW-1:0]]   = 1'b1;
                win_idx                 = cand[SELW-1:0];
            end
        end
    end

    assign in_ready = (load && !reset) ? grant : '0;
    assign take     = |in_ready;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (take) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (out_ready && !take) begin
                    state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= EMPTY;
            data_q <= '0;
            sel_q  <= '0;
            last_q <= SELW'(N-1);
        end else begin
            state <= state_nxt;
            if (take) begin
                data_q <= win_data;
                sel_q  <= win_idx;
                last_q <= win_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_reg.sv
// Self-checking bench for rr_mux_reg: directed scenarios plus a randomized run
// against a queue-free behavioural model of the round-robin output register.
module tb_rr_mux_reg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // N=4 instance
    logic         rst4;
    logic [3:0]   v4;
    logic [127:0] d4;
    logic         r4;
    logic [3:0]   rdy4;
    logic         ov4;
    logic [31:0]  od4;
    logic [1:0]   os4;

    // N=3 instance
    logic         rst3;
    logic [2:0]   v3;
    logic [95:0]  d3;
    logic         r3;
    logic [2:0]   rdy3;
    logic         ov3;
    logic [31:0]  od3;
    logic [1:0]   os3;

    int n_cmp = 0;
    int n_mis = 0;

    // behavioural model of the N=4 instance
    int          m_valid;
    int          m_sel;
    int          m_last;
    logic [31:0] m_data;

    rr_mux_reg #(.WIDTH(32), .N(4)) dut4 (
        .clk(clk), .reset(rst4), .in_valid(v4), .in_data(d4), .in_ready(rdy4),
        .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(r4)
    );

    rr_mux_reg #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .reset(rst3), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(r3)
    );

    function automatic int ref_pick(input logic [3:0] v, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] e;
        int g;
        e = '0;
        if (rst4) return e;
        g = ref_pick(v4, m_last);
        if ((m_valid == 0 || r4) && g >= 0) e[g] = 1'b1;
        return e;
    endfunction

    task automatic model_edge();
        int g;
        if (rst4) begin
            m_valid = 0; m_data = '0; m_sel = 0; m_last = 3;
        end else if (m_valid == 0 || r4) begin
            g = ref_pick(v4, m_last);
            if (g >= 0) begin
                m_valid = 1; m_data = d4[g*32 +: 32]; m_sel = g; m_last = g;
            end else begin
                m_valid = 0;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst4 = 1'b1; rst3 = 1'b1;
        v4 = 4'hF; d4 = {$urandom, $urandom, $urandom, $urandom}; r4 = 1'b1;
        v3 = 3'h7; d3 = '0; r3 = 1'b1;
        #2;
        n_cmp++;
        if (rdy4 !== 4'b0000) begin
            n_mis++; $display("FAIL reset_in_ready: got %b want 0000", rdy4);
        end
        tick();
        rst4 = 1'b0; rst3 = 1'b0; v4 = 4'h0; v3 = 3'h0;
        for (int i = 0; i < 3; i++) begin
            #2;
            n_cmp++;
            if (rdy4 !== 4'b0000) begin
                n_mis++; $display("FAIL idle_in_ready[%0d]: got %b want 0000", i, rdy4);
            end
            tick();
            n_cmp++;
            if (ov4 !== 1'b0 || od4 !== 32'h0 || os4 !== 2'd0) begin
                n_mis++;
                $display("FAIL idle_outputs[%0d]: got v=%b d=%h s=%0d want v=0 d=0 s=0", i, ov4, od4, os4);
            end
        end
    endtask

    task automatic test_round_robin();
        int seq[6] = '{0, 1, 2, 3, 0, 1};
        v4 = 4'hF; r4 = 1'b1;
        d4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        for (int i = 0; i < 6; i++) begin
            #2;
            n_cmp++;
            if (rdy4 !== exp_ready() || $countones(rdy4) != 1) begin
                n_mis++; $display("FAIL rr_in_ready[%0d]: got %b want %b", i, rdy4, exp_ready());
            end
            tick();
            n_cmp++;
            if (ov4 !== 1'b1 || os4 !== 2'(seq[i]) || od4 !== 32'hA0 + 32'(seq[i])) begin
                n_mis++;
                $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                         i, ov4, os4, od4, seq[i], 32'hA0 + 32'(seq[i]));
            end
        end
    endtask

    task automatic test_single();
        v4 = 4'b0100; r4 = 1'b1;
        d4 = {$urandom, 32'hDEADBEEF, $urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            #2;
            n_cmp++;
            if (rdy4 !== 4'b0100) begin
                n_mis++; $display("FAIL single_in_ready[%0d]: got %b want 0100", i, rdy4);
            end
            tick();
            n_cmp++;
            if (ov4 !== 1'b1 || os4 !== 2'd2 || od4 !== 32'hDEADBEEF) begin
                n_mis++;
                $display("FAIL single_out[%0d]: got v=%b s=%0d d=%h want v=1 s=2 d=deadbeef", i, ov4, os4, od4);
            end
        end
    endtask

    task automatic test_backpressure();
        v4 = 4'b0010; r4 = 1'b1;
        d4 = {$urandom, $urandom, 32'h11, $urandom};
        tick();
        v4 = 4'b1001; r4 = 1'b0;
        d4 = {32'h33, $urandom, $urandom, 32'h30};
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++;
            if (rdy4 !== 4'b0000) begin
                n_mis++; $display("FAIL stall_in_ready[%0d]: got %b want 0000", i, rdy4);
            end
            tick();
            n_cmp++;
            if (ov4 !== 1'b1 || od4 !== 32'h11 || os4 !== 2'd1) begin
                n_mis++;
                $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=1 d=11", i, ov4, os4, od4);
            end
        end
        r4 = 1'b1;
        #2;
        n_cmp++;
        if (rdy4 !== 4'b1000) begin
            n_mis++; $display("FAIL release_first: got %b want 1000", rdy4);
        end
        tick();
        n_cmp++;
        if (os4 !== 2'd3 || od4 !== 32'h33) begin
            n_mis++; $display("FAIL release_out3: got s=%0d d=%h want s=3 d=33", os4, od4);
        end
        #2;
        n_cmp++;
        if (rdy4 !== 4'b0001) begin
            n_mis++; $display("FAIL release_second: got %b want 0001", rdy4);
        end
        tick();
        n_cmp++;
        if (os4 !== 2'd0 || od4 !== 32'h30) begin
            n_mis++; $display("FAIL release_out0: got s=%0d d=%h want s=0 d=30", os4, od4);
        end
    endtask

    task automatic test_n3();
        int seq[7] = '{0, 1, 2, 0, 1, 2, 0};
        v4 = 4'h0; r4 = 1'b1;
        v3 = 3'h7; r3 = 1'b1;
        d3 = {32'hB2, 32'hB1, 32'hB0};
        for (int i = 0; i < 7; i++) begin
            #2;
            n_cmp++;
            if ($countones(rdy3) != 1 || rdy3 !== 3'(1 << seq[i])) begin
                n_mis++; $display("FAIL n3_in_ready[%0d]: got %b want %b", i, rdy3, 3'(1 << seq[i]));
            end
            tick();
            n_cmp++;
            if (ov3 !== 1'b1 || os3 !== 2'(seq[i]) || os3 == 2'd3 || od3 !== 32'hB0 + 32'(seq[i])) begin
                n_mis++;
                $display("FAIL n3_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d", i, ov3, os3, od3, seq[i]);
            end
        end
        v3 = 3'h0;
    endtask

    task automatic test_reset_mid();
        v4 = 4'h0; r4 = 1'b1;
        tick();
        v4 = 4'b0001; r4 = 1'b0;
        d4 = {$urandom, $urandom, $urandom, 32'h55};
        tick();
        n_cmp++;
        if (ov4 !== 1'b1 || od4 !== 32'h55) begin
            n_mis++; $display("FAIL mid_load: got v=%b d=%h want v=1 d=55", ov4, od4);
        end
        rst4 = 1'b1;
        #2;
        n_cmp++;
        if (rdy4 !== 4'b0000) begin
            n_mis++; $display("FAIL mid_reset_in_ready: got %b want 0000", rdy4);
        end
        tick();
        rst4 = 1'b0; v4 = 4'h0;
        n_cmp++;
        if (ov4 !== 1'b0 || od4 !== 32'h0 || os4 !== 2'd0) begin
            n_mis++; $display("FAIL mid_reset_out: got v=%b d=%h s=%0d want v=0 d=0 s=0", ov4, od4, os4);
        end
        v4 = 4'b0011; r4 = 1'b1;
        d4 = {$urandom, $urandom, 32'h66, 32'h77};
        #2;
        n_cmp++;
        if (rdy4 !== 4'b0001) begin
            n_mis++; $display("FAIL mid_first_grant: got %b want 0001", rdy4);
        end
        tick();
        n_cmp++;
        if (ov4 !== 1'b1 || os4 !== 2'd0 || od4 !== 32'h77) begin
            n_mis++; $display("FAIL mid_after: got v=%b s=%0d d=%h want v=1 s=0 d=77", ov4, os4, od4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst4 = ($urandom_range(0, 59) == 0);
            v4   = 4'($urandom_range(0, 15));
            d4   = {$urandom, $urandom, $urandom, $urandom};
            r4   = ($urandom_range(0, 3) != 0);
            #2;
            n_cmp++;
            if (rdy4 !== exp_ready()) begin
                n_mis++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, rdy4, exp_ready());
            end
            tick();
            n_cmp++;
            if (ov4 !== (m_valid != 0) ||
                (m_valid != 0 && (os4 !== 2'(m_sel) || od4 !== m_data))) begin
                n_mis++;
                $display("FAIL rand_out[%0d]: got v=%b s=%0d d=%h want v=%0d s=%0d d=%h",
                         i, ov4, os4, od4, m_valid, m_sel, m_data);
            end
        end
        rst4 = 1'b0;
    endtask

    initial begin
        m_valid = 0; m_data = '0; m_sel = 0; m_last = 3;
        test_reset();
        test_round_robin();
        test_single();
        test_backpressure();
        test_n3();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
